// File: rtl/vga_timing_pkg.sv
// Shared raster geometry for the VGA timing generator: default 640x480@60 Hz
// constants, derived totals/sync windows and the 10-bit counter type.
package vga_timing_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_CLK_DIV   = 2;
    localparam logic DEF_SYNC_ACTIVE = 1'b0;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    // Half-open window test [lo, hi) on a counter value.
    function automatic logic in_window(input cnt_t pos, input int lo, input int hi);
        return (int'(pos) >= lo) && (int'(pos) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator (master) to the picture
// generator (slave).
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic pix_en;
    logic vga_h_sync;
    logic vga_v_sync;
    logic in_display_area;
    cnt_t pix_x;
    cnt_t pix_y;
    logic line_start;
    logic frame_start;

    modport master (
        output pix_en, vga_h_sync, vga_v_sync, in_display_area,
               pix_x, pix_y, line_start, frame_start
    );

    modport slave (
        input pix_en, vga_h_sync, vga_v_sync, in_display_area,
              pix_x, pix_y, line_start, frame_start
    );

endinterface

// File: rtl/vga_timing_gen_pixel_clk_en.sv
// Pixel-rate enable: divides clk by CLK_DIV and emits a registered one-clk
// pix_en pulse in the cycle the divider sits at its last count.
module pixel_clk_en #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic pix_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;

    always_comb begin
        div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end

    // pix_en is registered from the next count so it is low during reset even
    // when CLK_DIV is 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            div_cnt <= div_next;
            pix_en  <= (div_next == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: position counters advanced by the pixel
// enable, with all raster outputs registered from the next counter values.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE   = DEF_H_VISIBLE,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_VISIBLE   = DEF_V_VISIBLE,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter int   CLK_DIV     = DEF_CLK_DIV,
    parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
    localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

    logic pix_en;
    cnt_t h_cnt;
    cnt_t v_cnt;
    cnt_t h_next;
    cnt_t v_next;

    logic h_sync_q;
    logic v_sync_q;
    logic display_q;
    cnt_t pix_x_q;
    cnt_t pix_y_q;
    logic line_start_q;
    logic frame_start_q;

    pixel_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_clk_en (
        .clk    (clk),
        .reset  (reset),
        .pix_en (pix_en)
    );

    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_next = '0;
                v_next = (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
            end else begin
                h_next = h_cnt + cnt_t'(1);
            end
        end
    end

    // Counters reset to the last position so the first advance lands on (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= H_LAST;
            v_cnt <= V_LAST;
        end else begin
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_sync_q      <= SYNC_IDLE;
            v_sync_q      <= SYNC_IDLE;
            display_q     <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= pix_en && (h_next == '0);
            frame_start_q <= pix_en && (h_next == '0) && (v_next == '0);
            if (pix_en) begin
                h_sync_q  <= in_window(h_next, HS_START, HS_END) ? SYNC_ACTIVE : SYNC_IDLE;
                v_sync_q  <= in_window(v_next, VS_START, VS_END) ? SYNC_ACTIVE : SYNC_IDLE;
                display_q <= in_window(h_next, 0, H_VISIBLE) && in_window(v_next, 0, V_VISIBLE);
                pix_x_q   <= h_next;
                pix_y_q   <= v_next;
            end
        end
    end

    assign vga.pix_en          = pix_en;
    assign vga.vga_h_sync      = h_sync_q;
    assign vga.vga_v_sync      = v_sync_q;
    assign vga.in_display_area = display_q;
    assign vga.pix_x           = pix_x_q;
    assign vga.pix_y           = pix_y_q;
    assign vga.line_start      = line_start_q;
    assign vga.frame_start     = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, small CLK_DIV=1 with
// active-high syncs, small CLK_DIV=3) checked cycle by cycle against a model.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef logic [25:0] obs_t;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    logic reset_c;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();
    vga_timing_gen_if if_c ();

    vga_timing_gen dut_a (
        .clk   (clk),
        .reset (reset_a),
        .vga   (if_a)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .CLK_DIV (1), .SYNC_ACTIVE (1'b1)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .vga   (if_b)
    );

    vga_timing_gen #(
        .H_VISIBLE (10), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (2),
        .CLK_DIV (3), .SYNC_ACTIVE (1'b0)
    ) dut_c (
        .clk   (clk),
        .reset (reset_c),
        .vga   (if_c)
    );

    obs_t obs_a;
    obs_t obs_b;
    obs_t obs_c;
    assign obs_a = {if_a.pix_en, if_a.vga_h_sync, if_a.vga_v_sync, if_a.in_display_area,
                    if_a.pix_x, if_a.pix_y, if_a.line_start, if_a.frame_start};
    assign obs_b = {if_b.pix_en, if_b.vga_h_sync, if_b.vga_v_sync, if_b.in_display_area,
                    if_b.pix_x, if_b.pix_y, if_b.line_start, if_b.frame_start};
    assign obs_c = {if_c.pix_en, if_c.vga_h_sync, if_c.vga_v_sync, if_c.in_display_area,
                    if_c.pix_x, if_c.pix_y, if_c.line_start, if_c.frame_start};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Expected outputs after k rising edges since reset release, computed
    // from the absolute edge count rather than by stepping counters.
    function automatic obs_t model(input int k, d, hv, hf, hs, hb, vv, vf, vs, vb,
                                   input logic sa);
        int   ht, vt, adv, n, h, v;
        logic en_next, adv_now, hsy, vsy, de, ls, fs;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        en_next = ((k + 1) % d == 0) && (k + 1 >= 2);
        adv_now = (k % d == 0) && (k >= 2);
        adv = (d == 1) ? k - 1 : k / d;
        if (adv <= 0) return {en_next, ~sa, ~sa, 1'b0, 20'd0, 2'b00};
        n = adv - 1;
        h = n % ht;
        v = (n / ht) % vt;
        hsy = (h >= hv + hf && h < hv + hf + hs) ? sa : ~sa;
        vsy = (v >= vv + vf && v < vv + vf + vs) ? sa : ~sa;
        de  = (h < hv) && (v < vv);
        ls  = adv_now && (h == 0);
        fs  = ls && (v == 0);
        return {en_next, hsy, vsy, de, 10'(h), 10'(v), ls, fs};
    endfunction

    function automatic obs_t model_a(input int k);
        return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    endfunction
    function automatic obs_t model_b(input int k);
        return model(k, 1, 8, 2, 3, 2, 6, 2, 2, 3, 1'b1);
    endfunction
    function automatic obs_t model_c(input int k);
        return model(k, 3, 10, 1, 2, 1, 4, 1, 1, 2, 1'b0);
    endfunction

    // Scoreboards: push the expectation at each edge, pop at the next negedge.
    int   k_a, k_b, k_c;
    obs_t q_a[$];
    obs_t q_b[$];
    obs_t q_c[$];

    always @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin k_a = 0; q_a.delete(); end
        else begin k_a++; q_a.push_back(model_a(k_a)); end
    end
    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin k_b = 0; q_b.delete(); end
        else begin k_b++; q_b.push_back(model_b(k_b)); end
    end
    always @(posedge clk or negedge reset_c) begin
        if (!reset_c) begin k_c = 0; q_c.delete(); end
        else begin k_c++; q_c.push_back(model_c(k_c)); end
    end

    always @(negedge clk) begin
        if (!reset_a) checkOutput("a_reset", obs_a, model_a(0));
        else if (q_a.size() > 0) checkOutput("a_out", obs_a, q_a.pop_front());
        if (!reset_b) checkOutput("b_reset", obs_b, model_b(0));
        else if (q_b.size() > 0) checkOutput("b_out", obs_b, q_b.pop_front());
        if (!reset_c) checkOutput("c_reset", obs_c, model_c(0));
        else if (q_c.size() > 0) checkOutput("c_out", obs_c, q_c.pop_front());
    end

    logic prev_hs_a = 1'b1;
    logic prev_de_a = 1'b0;
    int   low_a = 0;
    int   last_fall_a = -1;

    always @(negedge clk) begin
        if (!reset_a) begin
            prev_hs_a = 1'b1; prev_de_a = 1'b0; low_a = 0; last_fall_a = -1;
        end else begin
            if (prev_hs_a && !if_a.vga_h_sync) begin
                checkOutput("a_hs_fall_x", 32'(if_a.pix_x), 656);
                if (last_fall_a >= 0) checkOutput("a_hs_period", cyc - last_fall_a, 1600);
                last_fall_a = cyc;
                low_a = 0;
            end
            if (!if_a.vga_h_sync) low_a++;
            if (!prev_hs_a && if_a.vga_h_sync) begin
                checkOutput("a_hs_rise_x", 32'(if_a.pix_x), 752);
                checkOutput("a_hs_low_clks", low_a, 192);
            end
            if (prev_de_a && !if_a.in_display_area)
                checkOutput("a_de_fall_x", 32'(if_a.pix_x), 640);
            prev_hs_a = if_a.vga_h_sync;
            prev_de_a = if_a.in_display_area;
        end
    end

    // Frame-level measurements on the small CLK_DIV=1 instance.
    int   last_fs_b = -1;
    int   vs_on_b = 0;
    int   lines_b = 0;
    logic prev_de_b = 1'b0;

    always @(negedge clk) begin
        if (!reset_b) begin
            last_fs_b = -1; vs_on_b = 0; lines_b = 0; prev_de_b = 1'b0;
        end else begin
            if (if_b.vga_v_sync) vs_on_b++;
            if (if_b.frame_start) begin
                if (last_fs_b >= 0) begin
                    checkOutput("b_frame_period", cyc - last_fs_b, 195);
                    checkOutput("b_vs_active_clks", vs_on_b, 30);
                    checkOutput("b_display_lines", lines_b, 6);
                end
                last_fs_b = cyc;
                vs_on_b = 0;
                lines_b = 0;
            end
            if (!prev_de_b && if_b.in_display_area) lines_b++;
            prev_de_b = if_b.in_display_area;
        end
    end

    initial begin
        bit found;
        reset_a = 1'b0;
        reset_b = 1'b0;
        reset_c = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset_a = 1'b1;
        reset_b = 1'b1;
        reset_c = 1'b1;

        @(negedge clk);
        checkOutput("a_edge1_pix_en", if_a.pix_en, 1);
        checkOutput("a_edge1_fs", if_a.frame_start, 0);
        @(negedge clk);
        checkOutput("a_edge2_xy", {if_a.pix_x, if_a.pix_y}, 0);
        checkOutput("a_edge2_de", if_a.in_display_area, 1);
        checkOutput("a_edge2_fs", if_a.frame_start, 1);
        checkOutput("a_edge2_ls", if_a.line_start, 1);
        @(negedge clk);
        checkOutput("a_edge3_strobes", {if_a.frame_start, if_a.line_start}, 0);
        checkOutput("a_edge3_xy", {if_a.pix_x, if_a.pix_y}, 0);

        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (if_b.pix_x == 10'd14 && if_b.pix_y == 10'd12) found = 1'b1;
        end
        checkOutput("b_wrap_reached", found, 1);
        if (found) begin
            @(negedge clk);
            checkOutput("b_wrap_xy", {if_b.pix_x, if_b.pix_y}, 0);
            checkOutput("b_wrap_strobes", {if_b.frame_start, if_b.line_start}, 2'b11);
        end

        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (if_b.pix_x == 10'd5 && if_b.pix_y == 10'd3) found = 1'b1;
        end
        checkOutput("b_midframe_reached", found, 1);
        #1 reset_b = 1'b0;
        #1 checkOutput("b_async_reset", obs_b, model_b(0));
        repeat (3) @(negedge clk);
        #2 reset_b = 1'b1;
        @(negedge clk);
        checkOutput("b_restart_pix_en", if_b.pix_en, 1);
        @(negedge clk);
        checkOutput("b_restart_xy", {if_b.pix_x, if_b.pix_y}, 0);
        checkOutput("b_restart_fs", if_b.frame_start, 1);

        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            if (if_a.pix_x == 10'd300 && if_a.pix_y == 10'd2) found = 1'b1;
        end
        checkOutput("a_midframe_reached", found, 1);
        #1 reset_a = 1'b0;
        #1 checkOutput("a_async_reset", obs_a, model_a(0));
        repeat (3) @(negedge clk);
        #2 reset_a = 1'b1;
        @(negedge clk);
        checkOutput("a_restart_pix_en", if_a.pix_en, 1);
        checkOutput("a_restart_fs_early", if_a.frame_start, 0);
        @(negedge clk);
        checkOutput("a_restart_xy", {if_a.pix_x, if_a.pix_y}, 0);
        checkOutput("a_restart_strobes", {if_a.frame_start, if_a.line_start}, 2'b11);

        repeat (600) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
